// File: rtl/piso_serializer_if.sv
// Parallel word handshake plus serial output bundle for the PISO serializer.
// The master drives words and the bit strobe. The slave (serializer) returns the serial stream and status.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             shift_en;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, din_valid, shift_en,
        input  din_ready, dout, dout_valid, frame_start, busy
    );

    modport slave (
        input  din, din_valid, shift_en,
        output din_ready, dout, dout_valid, frame_start, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding register for gapless back-to-back frames.
//
//   state   | meaning
//   S_IDLE  | no frame on the link; waiting for a word
//   S_SHIFT | presenting bit r_bit_cnt of the frame in r_shreg
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    piso_serializer_if.slave    bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_bit_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             w_hold_full_nxt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_accept        = bus.din_valid && !r_hold_full;
        w_last          = (r_bit_cnt == LAST);
        w_shifted       = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt   = bus.din;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.shift_en && w_last) begin
                    // Frame boundary: queued word first, then a same-edge word, else drop to idle.
                    if (r_hold_full) begin
                        w_shreg_nxt     = r_hold;
                        w_hold_full_nxt = 1'b0;
                        w_bit_cnt_nxt   = '0;
                    end else if (w_accept) begin
                        w_shreg_nxt   = bus.din;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_shreg_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    if (bus.shift_en) begin
                        w_shreg_nxt   = w_shifted;
                        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    end
                    if (w_accept) begin
                        w_hold_nxt      = bus.din;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.dout        = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
    assign bus.dout_valid  = (r_state == S_SHIFT);
    assign bus.frame_start = (r_state == S_SHIFT) && (r_bit_cnt == '0);
    assign bus.din_ready   = !r_hold_full;
    assign bus.busy        = (r_state == S_SHIFT) || r_hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance checked against a bit scoreboard.
module tb_piso_serializer;
    logic clk;
    logic rst_n;

    piso_serializer_if #(.WIDTH(8)) bus0 ();
    piso_serializer_if #(.WIDTH(8)) bus1 ();

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus0));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic d;
        logic fs;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  valid0  = 0;
    int  valid1  = 0;
    int  gap0    = 0;
    int  last_wait = 0;
    int  base_v;
    int  base_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input bit sel, input logic [7:0] w, input bit lsb);
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            e.d  = lsb ? w[i] : w[7-i];
            e.fs = (i == 0);
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
    endtask

    // Bits are consumed on edges with shift_en high, so compare the bit presented just before such an edge.
    task automatic sample();
        sb_t e;
        if (rst_n) begin
            if (bus0.dout_valid) valid0++;
            else if (q0.size() != 0) gap0++;
            if (bus1.dout_valid) valid1++;
            if (bus0.dout_valid && bus0.shift_en) begin
                if (q0.size() == 0) chk("sb0_extra_bit", 32'(bus0.dout_valid), 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("sb0_dout", 32'(bus0.dout), 32'(e.d));
                    chk("sb0_frame_start", 32'(bus0.frame_start), 32'(e.fs));
                end
            end
            if (bus1.dout_valid && bus1.shift_en) begin
                if (q1.size() == 0) chk("sb1_extra_bit", 32'(bus1.dout_valid), 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("sb1_dout", 32'(bus1.dout), 32'(e.d));
                    chk("sb1_frame_start", 32'(bus1.frame_start), 32'(e.fs));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] w);
        int n = 0;
        if (sel) begin bus1.din = w; bus1.din_valid = 1'b1; end
        else     begin bus0.din = w; bus0.din_valid = 1'b1; end
        while (((sel ? bus1.din_ready : bus0.din_ready) == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready_timeout", 32'(n < 50), 32'd1);
        last_wait = n;
        tick();
        push_word(sel, w, !sel);
        if (sel) bus1.din_valid = 1'b0;
        else     bus0.din_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n = 0;
        while ((sel ? bus1.busy : bus0.busy) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
        chk({tag, "_sb_drained"}, 32'(sel ? q1.size() : q0.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus0.din = '0; bus0.din_valid = 1'b0; bus0.shift_en = 1'b1;
        bus1.din = '0; bus1.din_valid = 1'b0; bus1.shift_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout",        32'(bus0.dout),        32'd0);
        chk("rst_dout_valid",  32'(bus0.dout_valid),  32'd0);
        chk("rst_frame_start", 32'(bus0.frame_start), 32'd0);
        chk("rst_din_ready",   32'(bus0.din_ready),   32'd1);
        chk("rst_busy",        32'(bus0.busy),        32'd0);
        chk("rst_busy_msb",    32'(bus1.busy),        32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: single word, shift_en held high
        base_v = valid0;
        send(1'b0, 8'hA5);
        chk("t1_first_valid", 32'(bus0.dout_valid),  32'd1);
        chk("t1_first_fs",    32'(bus0.frame_start), 32'd1);
        repeat (8) tick();
        chk("t1_valid_c9", 32'(bus0.dout_valid), 32'd0);
        chk("t1_busy_c9",  32'(bus0.busy),       32'd0);
        chk("t1_valid_cycles", 32'(valid0 - base_v), 32'd8);
        chk("t1_sb_drained", 32'(q0.size()), 32'd0);

        // 2: second word parks in the hold register, third waits for the hand-off
        base_v = valid0; base_g = gap0;
        send(1'b0, 8'h3C);
        send(1'b0, 8'hC3);
        chk("t2_ready_low", 32'(bus0.din_ready), 32'd0);
        chk("t2_busy",      32'(bus0.busy),      32'd1);
        send(1'b0, 8'h5A);
        chk("t2_ready_low_cycles", 32'(last_wait), 32'd7);
        wait_idle(1'b0, "t2_idle");
        chk("t2_gaps", 32'(gap0 - base_g), 32'd0);
        chk("t2_valid_cycles", 32'(valid0 - base_v), 32'd24);

        // 3: direct load on the last-bit edge with the hold register empty
        base_v = valid0; base_g = gap0;
        send(1'b0, 8'h00);
        repeat (7) tick();
        chk("t3_pre_dout", 32'(bus0.dout),        32'd0);
        chk("t3_pre_fs",   32'(bus0.frame_start), 32'd0);
        send(1'b0, 8'hFF);
        chk("t3_switch_dout",  32'(bus0.dout),        32'd1);
        chk("t3_switch_fs",    32'(bus0.frame_start), 32'd1);
        chk("t3_switch_valid", 32'(bus0.dout_valid),  32'd1);
        chk("t3_hold_empty",   32'(bus0.din_ready),   32'd1);
        wait_idle(1'b0, "t3_idle");
        chk("t3_gaps", 32'(gap0 - base_g), 32'd0);
        chk("t3_valid_cycles", 32'(valid0 - base_v), 32'd16);

        // 4: strobe alternating, each bit must persist through the idle strobe cycle
        base_v = valid0;
        send(1'b0, 8'h96);
        for (int i = 0; i < 20; i++) begin
            bus0.shift_en = (i % 2 == 1);
            if (!bus0.shift_en && bus0.dout_valid && q0.size() != 0)
                chk("t4_bit_held", 32'(bus0.dout), 32'(q0[0].d));
            tick();
        end
        bus0.shift_en = 1'b1;
        chk("t4_valid_cycles", 32'(valid0 - base_v), 32'd16);
        wait_idle(1'b0, "t4_idle");

        // 5: MSB-first instance
        base_v = valid1;
        send(1'b1, 8'hC0);
        chk("t5_first_fs", 32'(bus1.frame_start), 32'd1);
        wait_idle(1'b1, "t5_idle");
        chk("t5_valid_cycles", 32'(valid1 - base_v), 32'd8);

        // 6: asynchronous reset mid-frame with the hold register full
        send(1'b0, 8'h5A);
        send(1'b0, 8'h33);
        tick(); tick();
        chk("t6_pre_busy",  32'(bus0.busy),      32'd1);
        chk("t6_pre_ready", 32'(bus0.din_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus0.dout_valid),  32'd0);
        chk("t6_rst_busy",  32'(bus0.busy),        32'd0);
        chk("t6_rst_fs",    32'(bus0.frame_start), 32'd0);
        chk("t6_rst_ready", 32'(bus0.din_ready),   32'd1);
        q0.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_idle", 32'(bus0.busy), 32'd0);
        base_v = valid0;
        send(1'b0, 8'h01);
        chk("t6_new_fs",   32'(bus0.frame_start), 32'd1);
        chk("t6_new_dout", 32'(bus0.dout),        32'd1);
        wait_idle(1'b0, "t6_idle");
        chk("t6_valid_cycles", 32'(valid0 - base_v), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out shifter; the transmit-side counterpart of the team's SIPO deserializer.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle.
- Provides per-bit valid and a frame-start marker.
- A one-word holding register allows back-to-back frames with no idle bit between them; it sits in front of any serial link the SIPO terminates.

Parameters:
WIDTH, 8, word width in bits; legal values are WIDTH >= 2
LSB_FIRST, 1, 1 = bit 0 transmitted first, 0 = bit WIDTH-1 transmitted first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a word
din_ready  output  1  block can accept a word this cycle
shift_en  input  1  bit strobe; serial output advances only on an edge where this is high
dout  output  1  serial data bit
dout_valid  output  1  dout carries a frame bit
frame_start  output  1  dout is the first bit of a frame
busy  output  1  shifting in progress or holding register occupied

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - Outputs: dout=0, dout_valid=0, frame_start=0, din_ready=1, busy=0.
  - Internal state: IDLE, bit_cnt=0, shift register=0, holding register empty.
  - Any partial frame is discarded with no completion.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Accept: a word is taken on a rising edge where din_valid && din_ready. din is ignored otherwise. din_ready = !hold_full.
- State machine, IDLE:
  - On accept: load the shift register from din, set bit_cnt=0, go to SHIFT.
  - The holding register stays empty.
  - shift_en is irrelevant in IDLE.
- State machine, SHIFT:
  - dout_valid=1.
  - dout = shreg[0] when LSB_FIRST=1, shreg[WIDTH-1] when LSB_FIRST=0.
  - frame_start = (bit_cnt==0).
  - On an edge with shift_en=0: shift register and bit_cnt hold, and the current bit stays on dout.
  - On an edge with shift_en=1 and bit_cnt < WIDTH-1: shift toward the output end and increment bit_cnt.
  - On an edge with shift_en=1 and bit_cnt == WIDTH-1 (last bit):
    - If hold_full: load the shift register from the holding register, empty the holding register, set bit_cnt=0, stay in SHIFT.
    - Else if an accept occurs on this same edge: load the shift register directly from din, set bit_cnt=0, stay in SHIFT.
    - Else: go to IDLE.
  - An accept in SHIFT that does not take the direct-load path above writes the holding register and sets hold_full.
- Latency: a word accepted at edge N presents its first bit (dout_valid=1, frame_start=1) in the cycle after edge N.
- Throughput: with shift_en held high and a supply of words, frames are contiguous, giving WIDTH valid bits per WIDTH cycles with no gap.
- Capacity: one word in the shift register plus one in the holding register. While the holding register is full, din_ready=0.
- Hold hand-off: when the holding register drains into the shift register, din_ready returns to 1 in the following cycle.
- busy = (state==SHIFT) || hold_full.
- bit_cnt width is clog2(WIDTH). The counter never exceeds WIDTH-1 and never wraps through unused codes.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, shift_en=1, accept 8'hA5 -> dout=1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start only on the first; dout_valid low on cycle 9; busy low on cycle 9.
2. Present 8'h3C, then 8'hC3 while the first is shifting, then a third word -> 16 contiguous valid bits (0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1); frame_start at bits 0 and 8; din_ready low from the second accept until the cycle after bit 7; the third word is accepted then.
3. Hold empty; present 8'hFF exactly on the last-bit edge of a preceding 8'h00 frame -> direct load, no idle cycle; dout switches from 0 to 1 with frame_start=1.
4. shift_en alternating 1,0 with 8'h96 -> each bit held for 2 cycles; frame occupies 16 cycles; bit order 0,1,1,0,1,0,0,1.
5. LSB_FIRST=0, accept 8'hC0 -> dout=1,1,0,0,0,0,0,0.
6. Assert rst_n=0 at bit 3 of a frame with the holding register full -> dout_valid, busy and frame_start drop immediately and din_ready=1; after release, a new word 8'h01 is transmitted cleanly from bit 0.
